ama_riscv_imem: RTL

//  Instruction main-memory backend sitting directly downstream of the icache

---
 rtl/ama_riscv_imem.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ama_riscv_imem.sv
// Instruction memory backend: fixed-latency registered read pipeline feeding an in-order response FIFO.
// Optional out-of-range request checking is enabled with `define MEM_OOR_CHECK_EN.
module ama_riscv_imem #(
  parameter int    ADDR_W     = 32,
  parameter int    BUS_W      = 128,
  parameter int    DEPTH      = 1024,
  parameter int    LAT        = 1,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BUS_W-1:0]  rsp_data,
  output logic              oor_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [BUS_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] outstanding;
  logic             accept;
  logic             rsp_fire;
  logic [IDX_W-1:0] idx;

  // Outstanding beats bound pipeline+FIFO occupancy, so the FIFO can never overflow.
  assign req_ready = !rst && (outstanding < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign idx       = req_data[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (accept && !rsp_fire) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && rsp_fire) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

`ifdef MEM_OOR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  logic oor_req;

  assign oor_req = ({1'b0, req_data} >= DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_err <= 1'b0;
    end else if (accept && oor_req) begin
      oor_err <= 1'b1;
    end
  end
`else
  assign oor_err = 1'b0;

  generate
    if (ADDR_W > IDX_W) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_data[ADDR_W-1:IDX_W];
    end
  endgenerate
`endif

  logic [LAT-1:0]   pipe_vld;
  logic [BUS_W-1:0] pipe_data [LAT];
  logic             pipe_out_vld;
  logic [BUS_W-1:0] pipe_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
`ifdef MEM_OOR_CHECK_EN
      pipe_data[0] <= oor_req ? '0 : mem[idx];
`else
      pipe_data[0] <= mem[idx];
`endif
    end
    for (int i = 1; i < LAT; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign pipe_out_vld  = pipe_vld[LAT-1];
  assign pipe_out_data = pipe_data[LAT-1];

  logic [BUS_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  // Pipeline beat bypasses the FIFO only when it is the oldest and is taken this cycle.
  assign push       = pipe_out_vld && !(fifo_empty && rsp_ready);
  assign pop        = !fifo_empty && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pipe_out_data;
  end

  assign rsp_valid = !fifo_empty || pipe_out_vld;

  always_comb begin
    rsp_data = '0;
    if (!fifo_empty) begin
      rsp_data = fifo_mem[rd_ptr];
    end else if (pipe_out_vld) begin
      rsp_data = pipe_out_data;
    end
  end

endmodule
